// File: rtl/store_unit.sv
// Store formatter: turns a byte-addressed SB/SH/SW request into one or two
// word-aligned memory writes with byte enables, handshaking with the core.
//   state | meaning
//   IDLE  | ready for a request; outputs quiet
//   BEAT0 | driving the lower (or only) word write until granted
//   BEAT1 | driving the upper word of a boundary-crossing store
module store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [31:0]           st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_done,
  output logic                  st_err,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_gnt
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] hi_addr_q, hi_addr_d;
  logic [31:0]           hi_data_q, hi_data_d;
  logic [3:0]            hi_be_q, hi_be_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [1:0]            off;
  logic [3:0]            mask;
  logic [31:0]           dz;
  logic [7:0]            wide_be;
  logic [63:0]           wide_d;
  logic                  legal;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] base_addr;

  assign st_ready  = resetn && (state_q == IDLE);
  assign accept    = st_valid && st_ready;
  assign st_done   = done_q;
  assign st_err    = err_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  always_comb begin
    off   = st_addr[1:0];
    legal = 1'b1;
    mask  = 4'b0001;
    dz    = {24'b0, st_data[7:0]};
    case (st_funct3)
      3'b000: mask = 4'b0001;
      3'b001: begin
        mask = 4'b0011;
        dz   = {16'b0, st_data[15:0]};
      end
      3'b010: begin
        mask = 4'b1111;
        dz   = st_data;
      end
      default: legal = 1'b0;
    endcase
    wide_be   = {4'b0, mask} << off;
    wide_d    = {32'b0, dz} << {off, 3'b000};
    base_addr = {st_addr[ADDR_WIDTH-1:2], 2'b00};
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    hi_addr_d   = hi_addr_q;
    hi_data_d   = hi_data_q;
    hi_be_d     = hi_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (legal) begin
            state_d     = BEAT0;
            mem_req_d   = 1'b1;
            mem_addr_d  = base_addr;
            mem_wdata_d = wide_d[31:0];
            mem_be_d    = wide_be[3:0];
            // Upper beat is staged now; a zero enable mask means no split.
            hi_addr_d   = base_addr + ADDR_WIDTH'(4);
            hi_data_d   = wide_d[63:32];
            hi_be_d     = wide_be[7:4];
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (mem_gnt) begin
          if (|hi_be_q) begin
            state_d     = BEAT1;
            mem_addr_d  = hi_addr_q;
            mem_wdata_d = hi_data_q;
            mem_be_d    = hi_be_q;
          end else begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
            done_d      = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_gnt) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          mem_be_d    = '0;
          done_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      hi_addr_q   <= '0;
      hi_data_q   <= '0;
      hi_be_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      hi_addr_q   <= hi_addr_d;
      hi_data_q   <= hi_data_d;
      hi_be_q     <= hi_be_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Bench for store_unit: directed cases plus randomized stores checked against
// a byte-by-byte model of where each store byte lands in memory.
module tb_store_unit;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          st_valid = 1'b0;
  logic          st_ready;
  logic [AW-1:0] st_addr = '0;
  logic [31:0]   st_data = '0;
  logic [2:0]    st_funct3 = '0;
  logic          st_done;
  logic          st_err;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_gnt = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr [2];
  logic [31:0] exp_wd   [2];
  logic [3:0]  exp_be   [2];
  int          nbeats;
  logic        model_legal;

  always #5 clk = ~clk;

  store_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_done(st_done), .st_err(st_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each store byte i goes to address a+i; its word and lane decide the beat.
  task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    int          sz;
    int          b;
    int          lane;
    logic [31:0] ba;
    logic [31:0] w0;
    model_legal = (f3 <= 3'd2);
    sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    w0 = a & 32'hFFFF_FFFC;
    nbeats = 1;
    exp_addr[0] = w0;
    exp_addr[1] = w0 + 32'd4;
    for (int j = 0; j < 2; j++) begin
      exp_wd[j] = '0;
      exp_be[j] = '0;
    end
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      b = ((ba & 32'hFFFF_FFFC) == w0) ? 0 : 1;
      if (b == 1) nbeats = 2;
      lane = int'(ba[1:0]);
      exp_be[b][lane] = 1'b1;
      exp_wd[b][8*lane +: 8] = d[8*i +: 8];
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the
  // st_done cycle so a following call exercises back-to-back acceptance.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                           input int stall0, input int stall1);
    int st;
    model(a, d, f3);
    chk("ready_before_accept", st_ready, 1);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
    @(negedge clk);
    st_valid  = 1'b0;
    st_addr   = $urandom;
    st_data   = $urandom;
    st_funct3 = 3'($urandom);
    if (!model_legal) begin
      chk("illegal_no_req", mem_req, 0);
      chk("illegal_done", st_done, 1);
      chk("illegal_err", st_err, 1);
      chk("illegal_ready", st_ready, 1);
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      st = (b == 0) ? stall0 : stall1;
      for (int k = 0; k <= st; k++) begin
        chk("beat_req", mem_req, 1);
        chk("beat_addr", mem_addr, exp_addr[b]);
        chk("beat_wdata", mem_wdata, exp_wd[b]);
        chk("beat_be", mem_be, exp_be[b]);
        chk("beat_no_done", st_done, 0);
        chk("beat_not_ready", st_ready, 0);
        mem_gnt = (k == st);
        @(negedge clk);
      end
    end
    mem_gnt = 1'b0;
    chk("done_pulse", st_done, 1);
    chk("done_no_err", st_err, 0);
    chk("done_req_low", mem_req, 0);
    chk("idle_addr_zero", mem_addr, 0);
    chk("idle_wdata_zero", mem_wdata, 0);
    chk("idle_be_zero", mem_be, 0);
    chk("done_ready", st_ready, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [2:0]  rf;
    int          r;

    repeat (3) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_done", st_done, 0);
    chk("rst_err", st_err, 0);
    chk("rst_ready_low", st_ready, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", st_ready, 1);

    run_store(32'h0000_0100, 32'hDEAD_BEEF, 3'b010, 0, 0);
    @(negedge clk);
    chk("done_single_cycle", st_done, 0);
    run_store(32'h0000_0203, 32'h1234_5678, 3'b000, 0, 0);
    run_store(32'h0000_0103, 32'hFFFF_ABCD, 3'b001, 0, 0);
    run_store(32'hFFFF_FFFE, 32'hCAFE_BABE, 3'b010, 3, 0);

    run_store(32'h0000_0040, 32'h5555_5555, 3'b011, 0, 0);
    @(negedge clk);
    chk("illegal_done_cleared", st_done, 0);
    chk("illegal_err_cleared", st_err, 0);
    chk("illegal_still_no_req", mem_req, 0);
    run_store(32'h0000_0041, 32'h0000_00A5, 3'b000, 1, 0);

    // Reset during BEAT1 of a split SW drops the beat without completion.
    model(32'h0000_0101, 32'h0102_0304, 3'b010);
    st_valid = 1'b1; st_addr = 32'h0000_0101; st_data = 32'h0102_0304; st_funct3 = 3'b010;
    @(negedge clk);
    st_valid = 1'b0;
    chk("rst_op_beat0_be", mem_be, exp_be[0]);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rst_op_beat1_req", mem_req, 1);
    chk("rst_op_beat1_be", mem_be, exp_be[1]);
    resetn = 1'b0;
    #1;
    chk("rst_op_ready_low", st_ready, 0);
    @(negedge clk);
    chk("rst_op_req", mem_req, 0);
    chk("rst_op_be", mem_be, 0);
    chk("rst_op_addr", mem_addr, 0);
    chk("rst_op_done", st_done, 0);
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_op_no_done", st_done, 0);
      chk("rst_op_no_req", mem_req, 0);
    end
    run_store(32'h0000_0302, 32'h0000_0077, 3'b000, 0, 0);

    for (int n = 0; n < 60; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      rf = (r < 9) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      run_store(ra, $urandom, rf, $urandom_range(0, 2), $urandom_range(0, 2));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
